// File: rtl/img_stream_pkg.sv
// img_stream_pkg: shared types and constants for the pixel streamer.
// Holds the FSM state encoding and the RGB field layout.
package img_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2,
        ST_ABORT  = 2'd3
    } state_e;

    localparam int PIX_W_DEF = 24;

    localparam int R_HI = 23;
    localparam int R_LO = 16;
    localparam int G_HI = 15;
    localparam int G_LO = 8;
    localparam int B_HI = 7;
    localparam int B_LO = 0;

endpackage

// File: rtl/pix_fifo.sv
// pix_fifo: small synchronous FIFO holding prefetched pixels.
// Synchronous clear drops all contents; push and pop together keep the count.
module pix_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             wdata_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             rdata_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + PW'(1);
            if (pop_i)  rptr_q <= rptr_q + PW'(1);
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage array, no reset needed since reads are gated by count
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/img_pixel_streamer.sv
// img_pixel_streamer: serves frame pixels to a pull-based reader.
// Prefetches from a fixed-latency frame buffer into pix_fifo.
module img_pixel_streamer
    import img_stream_pkg::*;
#(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int ADDR_W     = 32,
    parameter int PIX_W      = PIX_W_DEF,
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_rdy,
    input  logic              get_next_pix,
    output logic              pix_rdy,
    output logic [PIX_W-1:0]  pixel_data,
    output logic              img_done,
    input  logic [ADDR_W-1:0] frame_base,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic              busy
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int CNT_W  = $clog2(NPIX+1);
    localparam int FCNT_W = $clog2(FIFO_DEPTH+1);
    localparam int INF_W  = $clog2(RD_LATENCY+1);
    localparam int OCC_W  = $clog2(FIFO_DEPTH+RD_LATENCY+1);

    state_e state_q, state_d;

    logic rdy_q, rdy_prev_q;
    logic rise, fall;

    logic [ADDR_W-1:0]     base_q, base_d;
    logic [CNT_W-1:0]      issue_q, issue_d;
    logic [CNT_W-1:0]      deliv_q, deliv_d;
    logic                  pend_q, pend_d;
    logic                  prdy_q, prdy_d;
    logic [PIX_W-1:0]      pix_q, pix_d;
    logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;

    logic [INF_W-1:0]  inflight;
    logic [OCC_W-1:0]  occ;
    logic [FCNT_W-1:0] f_count;
    logic              f_empty;
    logic [PIX_W-1:0]  f_head;

    logic start, abort, accept, serve, set_pend;
    logic push, clr, last_pix, rd_ok;

    assign rise     = rdy_q & ~rdy_prev_q;
    assign fall     = ~rdy_q & rdy_prev_q;
    assign occ      = OCC_W'(f_count) + OCC_W'(inflight);
    assign rd_ok    = (issue_q < CNT_W'(NPIX)) &&
                      (occ < OCC_W'(FIFO_DEPTH));
    assign last_pix = prdy_q && (deliv_q == CNT_W'(NPIX-1));

    // Count reads still travelling through the memory latency
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight = inflight + INF_W'(vpipe_q[i]);
    end

    // Single register stage on cpu_rdy plus history for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_q      <= 1'b0;
            rdy_prev_q <= 1'b0;
        end else begin
            rdy_q      <= cpu_rdy;
            rdy_prev_q <= rdy_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next-state logic; abort wins over frame completion
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (rise) state_d = ST_STREAM;
            ST_STREAM: begin
                if (fall)          state_d = ST_ABORT;
                else if (last_pix) state_d = ST_DONE;
            end
            ST_DONE:   if (!rdy_q) state_d = ST_IDLE;
            ST_ABORT:  if (vpipe_q == '0) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: issue, FIFO control, request handling, status
    always_comb begin
        start    = 1'b0;
        abort    = 1'b0;
        mem_rd   = 1'b0;
        busy     = 1'b0;
        img_done = 1'b0;
        clr      = 1'b0;
        push     = 1'b0;
        accept   = 1'b0;
        serve    = 1'b0;
        set_pend = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                start = rise;
                clr   = rise;
            end
            ST_STREAM: begin
                busy  = 1'b1;
                abort = fall;
                clr   = fall;
                if (!fall) begin
                    mem_rd   = rd_ok;
                    push     = vpipe_q[RD_LATENCY-1];
                    accept   = get_next_pix && !pend_q && !prdy_q;
                    serve    = !f_empty && (pend_q || accept);
                    set_pend = accept && f_empty;
                end
            end
            ST_DONE:  img_done = rdy_q;
            ST_ABORT: busy = 1'b1;
            default:  ;
        endcase
    end

    assign mem_addr   = mem_rd ? base_q + ADDR_W'(issue_q) : '0;
    assign pix_rdy    = prdy_q;
    assign pixel_data = pix_q;

    // Datapath next-state: counters, pending flag, output pixel, valid pipe
    always_comb begin
        base_d  = base_q;
        issue_d = issue_q;
        deliv_d = deliv_q;
        pend_d  = pend_q;
        prdy_d  = 1'b0;
        pix_d   = pix_q;
        vpipe_d = '0;
        vpipe_d[0] = mem_rd;
        for (int i = 1; i < RD_LATENCY; i++)
            vpipe_d[i] = vpipe_q[i-1];
        if (mem_rd) issue_d = issue_q + CNT_W'(1);
        if (prdy_q) deliv_d = deliv_q + CNT_W'(1);
        if (serve) begin
            prdy_d = 1'b1;
            pix_d  = f_head;
            pend_d = 1'b0;
        end else if (set_pend) begin
            pend_d = 1'b1;
        end
        if (abort) pend_d = 1'b0;
        if (start) begin
            base_d  = frame_base;
            issue_d = '0;
            deliv_d = '0;
            pend_d  = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q  <= '0;
            issue_q <= '0;
            deliv_q <= '0;
            pend_q  <= 1'b0;
            prdy_q  <= 1'b0;
            pix_q   <= '0;
            vpipe_q <= '0;
        end else begin
            base_q  <= base_d;
            issue_q <= issue_d;
            deliv_q <= deliv_d;
            pend_q  <= pend_d;
            prdy_q  <= prdy_d;
            pix_q   <= pix_d;
            vpipe_q <= vpipe_d;
        end
    end

    pix_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .clr_i   (clr),
        .push_i  (push),
        .wdata_i (mem_rdata),
        .pop_i   (serve),
        .rdata_o (f_head),
        .empty_o (f_empty),
        .count_o (f_count)
    );

endmodule

// File: tb/tb_img_pixel_streamer.sv
// tb_img_pixel_streamer: directed and randomized checks of the pixel streamer.
// Reference: pixel k of a frame is 24'h100000+k, read k at frame_base+k.
module tb_img_pixel_streamer;

    localparam int NPIX = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_rdy;
    logic        get_next_pix;
    logic        pix_rdy;
    logic [23:0] pixel_data;
    logic        img_done;
    logic [31:0] frame_base;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [23:0] mem_rdata;
    logic        busy;

    logic [31:0] tb_base;
    logic [23:0] d1;
    logic [23:0] got_q [$];
    int          errors   = 0;
    int          checks   = 0;
    int          n_issued = 0;

    always #5 clk = ~clk;

    img_pixel_streamer #(
        .IMG_W      (4),
        .IMG_H      (2),
        .ADDR_W     (32),
        .PIX_W      (24),
        .RD_LATENCY (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_rdy      (cpu_rdy),
        .get_next_pix (get_next_pix),
        .pix_rdy      (pix_rdy),
        .pixel_data   (pixel_data),
        .img_done     (img_done),
        .frame_base   (frame_base),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Frame buffer: two-cycle read latency, word at base+i holds 0x100000+i
    always @(posedge clk) begin
        d1 <= mem_rd ? 24'h100000 + 24'(mem_addr - tb_base) : 24'hxxxxxx;
        mem_rdata <= d1;
    end

    // Monitor: read address sequence and delivered pixels
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_rd) begin
                chk("issue_addr", mem_addr, tb_base + 32'(n_issued));
                chk("issue_in_frame", 32'(n_issued < NPIX), 32'd1);
                n_issued++;
            end
            if (pix_rdy) got_q.push_back(pixel_data);
        end
    end

    task automatic start_frame(input logic [31:0] b);
        @(posedge clk); #1;
        frame_base = b;
        tb_base    = b;
        n_issued   = 0;
        got_q.delete();
        cpu_rdy    = 1'b1;
    endtask

    task automatic stop_frame(input string tag);
        @(posedge clk); #1 cpu_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_done_clr"}, 32'(img_done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic req();
        @(posedge clk); #1 get_next_pix = 1'b1;
        @(posedge clk); #1 get_next_pix = 1'b0;
    endtask

    task automatic wait_pixels(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic check_seq(input string tag, input int n);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(n));
        for (int k = 0; k < got_q.size() && k < n; k++)
            chk({tag, "_pix"}, 32'(got_q[k]), 32'h100000 + 32'(k));
    endtask

    task automatic run_random();
        for (int i = 0; i < 60 && got_q.size() < NPIX; i++) begin
            req();
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_pixels(NPIX, 10);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pix_rdy"}, 32'(pix_rdy), 32'd0);
        chk({tag, "_pixel"}, 32'(pixel_data), 32'd0);
        chk({tag, "_img_done"}, 32'(img_done), 32'd0);
        chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        cpu_rdy      = 1'b0;
        get_next_pix = 1'b0;
        frame_base   = '0;
        tb_base      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("rst");
        @(posedge clk); #1 reset_n = 1'b1;

        // Prefetch fills the FIFO and stalls
        start_frame(32'h40);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("fill_issued", 32'(n_issued), 32'd4);
        chk("fill_mem_rd", 32'(mem_rd), 32'd0);
        chk("fill_busy", 32'(busy), 32'd1);

        // Requests every third cycle
        for (int k = 0; k < NPIX; k++) begin
            req();
            @(negedge clk);
            chk("slow_rdy", 32'(pix_rdy), 32'd1);
            chk("slow_data", 32'(pixel_data), 32'h100000 + 32'(k));
            chk("slow_done_early", 32'(img_done), 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("slow_done_set", 32'(img_done), 32'd1);
        #1;
        check_seq("slow", NPIX);
        chk("slow_issued", 32'(n_issued), 32'd8);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(img_done), 32'd1);
        stop_frame("slow");

        // Request on an empty FIFO goes pending; second request dropped
        start_frame(32'hFFFF_FFFE);
        @(posedge clk);
        @(posedge clk); #1 get_next_pix = 1'b1;
        @(negedge clk);
        chk("pend_busy", 32'(busy), 32'd1);
        chk("pend_no_rdy", 32'(pix_rdy), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1 get_next_pix = 1'b0;
        wait_pixels(1, 10);
        check_seq("pend_first", 1);
        repeat (6) @(negedge clk);
        #1;
        chk("pend_drop", 32'(got_q.size()), 32'd1);
        run_random();
        check_seq("pend_rest", NPIX);
        @(negedge clk);
        chk("pend_done", 32'(img_done), 32'd1);
        stop_frame("pend");

        // Back-to-back requests held high
        start_frame($urandom());
        @(posedge clk); #1 get_next_pix = 1'b1;
        for (int i = 0; i < 80 && got_q.size() < NPIX; i++) begin
            @(negedge clk); #1;
        end
        @(posedge clk); #1 get_next_pix = 1'b0;
        @(negedge clk);
        chk("b2b_done", 32'(img_done), 32'd1);
        #1;
        check_seq("b2b", NPIX);
        chk("b2b_issued", 32'(n_issued), 32'd8);
        stop_frame("b2b");

        // Abort after three pixels with reads in flight
        start_frame(32'h1000);
        repeat (10) @(posedge clk);
        req();
        req();
        req();
        cpu_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 12; i++) begin
            chk("abort_no_done", 32'(img_done), 32'd0);
            chk("abort_no_rdy", 32'(pix_rdy), 32'd0);
            @(negedge clk);
        end
        chk("abort_idle", 32'(busy), 32'd0);
        #1;
        check_seq("abort", 3);
        start_frame(32'h2000);
        run_random();
        check_seq("restart", NPIX);
        stop_frame("restart");

        // Asynchronous reset in the middle of a frame
        start_frame(32'h300);
        repeat (8) @(posedge clk);
        req();
        req();
        @(negedge clk);
        chk("prerst_busy", 32'(busy), 32'd1);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        chk_zero("async_rst");
        cpu_rdy = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        start_frame(32'h300);
        run_random();
        check_seq("rst_restart", NPIX);
        stop_frame("rst_restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
